tdm_dual_demux4: RTL and testbench
==================================

# tdm_dual_demux4

Dual 1-to-4 time-division demultiplexer: the receive end of a link where a dual 4:1 multiplexer serializes two 4-bit words (C0..C3, D0..D3) onto two lines (1Y, 2Y), one slot per enabled cycle. It tracks frame alignment with a sync marker and rebuilds both words in slot registers. It presents each completed frame as a parallel, registered word pair with a one-cycle valid pulse. It sits directly downstream of the mux-based serializer in the datapath.

## Interface
- No parameters. Word width is 4, lane count is 2 and slot count is 4, all fixed.
- in_clk  input  1  single clock; all state changes on its rising edge
- in_rst_n  input  1  reset, asynchronous, active-low
- in_en  input  1  slot strobe; a slot is sampled only on cycles with in_en=1
- in_sync  input  1  frame marker; high on the slot-0 sample of each frame
- in_1Y  input  1  lane-1 serial data (C word)
- in_2Y  input  1  lane-2 serial data (D word)
- in_G1  input  1  lane-1 strobe, active-low; 1 forces the sampled lane-1 bit to 0
- in_G2  input  1  lane-2 strobe, active-low; 1 forces the sampled lane-2 bit to 0
- out_C  output  4  last complete lane-1 word; bit k = slot k
- out_D  output  4  last complete lane-2 word; bit k = slot k
- out_valid  output  1  one-cycle pulse when out_C/out_D take a new frame
- out_locked  output  1  1 while state is LOCK
- out_err  output  1  one-cycle pulse on an alignment error
- out_frame_cnt  output  8  count of completed frames, wraps 255->0

## Operation
- Effective bits: b1 = in_1Y & ~in_G1 and b2 = in_2Y & ~in_G2. These match the mux output, which is forced low while its strobe is high.
- Internal state:
  - 2-bit slot counter `slot`
  - 3-bit shadow registers for slots 0..2 on each lane
  - FSM with states HUNT and LOCK
- Cycles with in_en=0 are ignored entirely. in_sync, data and gates are don't-care on those cycles.
- HUNT:
  - in_en=1 with in_sync=0: stay in HUNT, discard the sample.
  - in_en=1 with in_sync=1: store b1/b2 into shadow[0], set slot=1, go to LOCK.
- LOCK, on every cycle with in_en=1:
  - slot in 1..2 and in_sync=0: store into shadow[slot], slot+=1.
  - slot=3 and in_sync=0: load out_C={b1,shadow1[2:0]} and out_D={b2,shadow2[2:0]}; pulse out_valid; out_frame_cnt+=1 (mod 256); set slot=0.
  - slot=0 and in_sync=1: store into shadow[0], slot=1.
  - slot=0 and in_sync=0 (missing marker): pulse out_err, go to HUNT, discard the sample.
  - slot in 1..3 and in_sync=1 (early marker): pulse out_err, discard the partial frame, treat the sample as slot 0 (store into shadow[0], slot=1), stay in LOCK.
- out_C/out_D hold their value until the next completed frame. Partial or errored frames never reach the outputs.
- in_G1/in_G2 are evaluated per sample. A gate may change mid-frame, and only the affected slots read 0.

## Timing
- Reset (in_rst_n=0, asynchronous): state HUNT, slot=0, shadows 0. All outputs go to 0: out_C=0, out_D=0, out_valid=0, out_locked=0, out_err=0, out_frame_cnt=0.
- Reset release is synchronous in effect. The first sample is the first in_en=1 edge with in_rst_n=1.
- Reset asserted mid-frame discards the frame immediately. After release the block re-enters HUNT.
- Latency: out_C/out_D/out_valid change on the same rising edge that samples slot 3. They are visible during the following cycle.
- out_valid is high for exactly one cycle per completed frame, even if in_en stays low afterwards.
- Back-to-back frames (in_en=1 continuously) give one out_valid every 4 cycles.
- out_err is a single-cycle pulse and is never asserted in the same cycle as out_valid.
- out_locked goes high the cycle after the HUNT->LOCK edge. It goes low the cycle after a missing-marker error.
- out_frame_cnt is unchanged by errors. It wraps from 255 to 0 with no flag.

## Test plan
- Reset then lock: after reset, check all outputs are 0. Send sync frame C=1010b, D=0110b (slot0 first, in_en=1, G1=G2=0). Expect out_C=1010, out_D=0110, out_valid for 1 cycle, out_frame_cnt=1, out_locked=1.
- Gated lanes: send frame 1111/1111 with G1=1 on slots 1 and 3 and G2=1 throughout. Expect out_C=0101, out_D=0000.
- Stalls: same frame with in_en=0 for 3 cycles between each slot, with toggling garbage on in_1Y and in_sync during the stalls. Expect an identical result and a single out_valid.
- Early sync: after slot 1, assert in_sync with data 1/0. Expect out_err pulse, out_C/out_D unchanged. That sample becomes slot 0, and the next 3 slots complete the frame.
- Missing sync: locked, send slot 0 with in_sync=0. Expect out_err, out_locked=0, and no output update until the next sync frame.
- Wrap and reset: send 256 continuous frames and expect out_frame_cnt=0 after the last. Pull in_rst_n low mid-frame and expect all outputs 0 asynchronously.

Source files
------------

// File: rtl/tdm_dual_demux4.sv
// tdm_dual_demux4: receive end of a dual 4:1 TDM link. Tracks frame
// alignment from a slot-0 sync marker and rebuilds the C/D words lane by lane.

// One lane: shadow bits for slots 0..2 plus the registered output word.
module tdm_demux_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_bit,
    input  logic       store,
    input  logic [1:0] store_idx,
    input  logic       load,
    output logic [3:0] word
);
    logic [2:0] shadow_q;

    // Capture the slot 0..2 bits; on slot 3, publish the whole word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            word     <= '0;
        end else begin
            for (int k = 0; k < 3; k++)
                if (store && store_idx == 2'(k))
                    shadow_q[k] <= sample_bit;
            if (load)
                word <= {sample_bit, shadow_q};
        end
    end
endmodule

module tdm_dual_demux4 (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_en,
    input  logic       in_sync,
    input  logic       in_1Y,
    input  logic       in_2Y,
    input  logic       in_G1,
    input  logic       in_G2,
    output logic [3:0] out_C,
    output logic [3:0] out_D,
    output logic       out_valid,
    output logic       out_locked,
    output logic       out_err,
    output logic [7:0] out_frame_cnt
);
    localparam int NUM_LANES = 2;
    localparam int VEC_W     = 4;

    typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

    state_t state_q, state_d;
    logic [1:0] slot_q, slot_d;
    logic       store, load, err_d;
    logic [1:0] store_idx;

    logic [NUM_LANES-1:0]            lane_bit;
    logic [NUM_LANES-1:0][VEC_W-1:0] lane_word;

    // Strobes are active-low; a gated lane reads 0 just like the mux output.
    assign lane_bit = {in_2Y & ~in_G2, in_1Y & ~in_G1};

    // State, slot counter and single-cycle status pulses.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q       <= HUNT;
            slot_q        <= '0;
            out_valid     <= 1'b0;
            out_err       <= 1'b0;
            out_frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            out_valid <= load;
            out_err   <= err_d;
            if (load)
                out_frame_cnt <= out_frame_cnt + 8'd1;
        end
    end

    // Alignment FSM: decides what each enabled sample does.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        store     = 1'b0;
        store_idx = slot_q;
        load      = 1'b0;
        err_d     = 1'b0;
        if (in_en) begin
            unique case (state_q)
                HUNT: begin
                    if (in_sync) begin
                        store     = 1'b1;
                        store_idx = 2'd0;
                        slot_d    = 2'd1;
                        state_d   = LOCK;
                    end
                end
                LOCK: begin
                    if (in_sync) begin
                        // Marker restarts the frame; off slot 0 it is an early marker.
                        err_d     = (slot_q != 2'd0);
                        store     = 1'b1;
                        store_idx = 2'd0;
                        slot_d    = 2'd1;
                    end else if (slot_q == 2'd0) begin
                        // Missing marker: drop alignment, slot already 0.
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else if (slot_q == 2'd3) begin
                        load   = 1'b1;
                        slot_d = 2'd0;
                    end else begin
                        store  = 1'b1;
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        tdm_demux_lane u_lane (
            .clk        (in_clk),
            .rst_n      (in_rst_n),
            .sample_bit (lane_bit[g]),
            .store      (store),
            .store_idx  (store_idx),
            .load       (load),
            .word       (lane_word[g])
        );
    end

    assign out_C      = lane_word[0];
    assign out_D      = lane_word[1];
    assign out_locked = (state_q == LOCK);
endmodule

// File: tb/tb_tdm_dual_demux4.sv
// Randomized bench for tdm_dual_demux4 against a queue-based frame model.
module tb_tdm_dual_demux4;
    logic       in_clk = 1'b0;
    logic       in_rst_n, in_en, in_sync, in_1Y, in_2Y, in_G1, in_G2;
    logic [3:0] out_C, out_D;
    logic       out_valid, out_locked, out_err;
    logic [7:0] out_frame_cnt;

    tdm_dual_demux4 dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_en(in_en), .in_sync(in_sync),
        .in_1Y(in_1Y), .in_2Y(in_2Y), .in_G1(in_G1), .in_G2(in_G2),
        .out_C(out_C), .out_D(out_D), .out_valid(out_valid),
        .out_locked(out_locked), .out_err(out_err), .out_frame_cnt(out_frame_cnt)
    );

    always #5 in_clk = ~in_clk;

    int n_pass = 0, n_total = 0;

    // Model: aligned flag plus the bits collected so far in the current frame.
    bit       m_aligned;
    bit       q1[$], q2[$];
    bit [3:0] m_c, m_d;
    bit [7:0] m_cnt;
    bit       m_valid, m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_aligned = 0; q1.delete(); q2.delete();
        m_c = 0; m_d = 0; m_cnt = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic model_step(input bit en, sync, y1, y2, g1, g2);
        bit b1, b2;
        int w1, w2;
        m_valid = 0; m_err = 0;
        if (!en) return;
        b1 = y1 & ~g1;
        b2 = y2 & ~g2;
        if (sync) begin
            // Any marker starts a fresh frame; leftovers mean it came early.
            if (m_aligned && q1.size() != 0) m_err = 1;
            m_aligned = 1;
            q1.delete(); q2.delete();
            q1.push_back(b1); q2.push_back(b2);
        end else if (m_aligned) begin
            if (q1.size() == 0) begin
                m_err = 1; m_aligned = 0;
            end else begin
                q1.push_back(b1); q2.push_back(b2);
                if (q1.size() == 4) begin
                    w1 = 0; w2 = 0;
                    for (int k = 0; k < 4; k++) begin
                        w1 += int'(q1[k]) * (1 << k);
                        w2 += int'(q2[k]) * (1 << k);
                    end
                    m_c = 4'(w1); m_d = 4'(w2);
                    m_valid = 1; m_cnt = m_cnt + 8'd1;
                    q1.delete(); q2.delete();
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_C"}, 32'(out_C), 32'(m_c));
        chk({tag, "_D"}, 32'(out_D), 32'(m_d));
        chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, "_locked"}, 32'(out_locked), 32'(m_aligned));
        chk({tag, "_err"}, 32'(out_err), 32'(m_err));
        chk({tag, "_cnt"}, 32'(out_frame_cnt), 32'(m_cnt));
    endtask

    task automatic drive(input string tag, input bit en, sync, y1, y2, g1, g2);
        in_en = en; in_sync = sync; in_1Y = y1; in_2Y = y2; in_G1 = g1; in_G2 = g2;
        @(posedge in_clk);
        model_step(en, sync, y1, y2, g1, g2);
        #1;
        check_all(tag);
    endtask

    task automatic send_frame(input string tag, input bit [3:0] c, d, g1m, g2m, input bit stall);
        for (int k = 0; k < 4; k++) begin
            drive(tag, 1'b1, k == 0, c[k], d[k], g1m[k], g2m[k]);
            if (stall && k < 3)
                for (int s = 0; s < 3; s++)
                    drive({tag, "_stall"}, 1'b0, 1'($urandom), 1'(s), 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic do_reset();
        in_rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge in_clk);
        in_rst_n = 1'b1;
    endtask

    initial begin
        in_rst_n = 1'b0; in_en = 0; in_sync = 0; in_1Y = 0; in_2Y = 0; in_G1 = 0; in_G2 = 0;
        model_reset();
        #12;
        check_all("por");
        @(negedge in_clk);
        in_rst_n = 1'b1;

        send_frame("lock", 4'b1010, 4'b0110, 4'b0000, 4'b0000, 1'b0);
        chk("lock_C_const", 32'(out_C), 32'h a);
        chk("lock_D_const", 32'(out_D), 32'h 6);
        chk("lock_valid_const", 32'(out_valid), 32'd1);
        chk("lock_cnt_const", 32'(out_frame_cnt), 32'd1);
        chk("lock_locked_const", 32'(out_locked), 32'd1);

        send_frame("gate", 4'b1111, 4'b1111, 4'b1010, 4'b1111, 1'b0);
        chk("gate_C_const", 32'(out_C), 32'h5);
        chk("gate_D_const", 32'(out_D), 32'h0);

        send_frame("stall", 4'b1111, 4'b1111, 4'b1010, 4'b1111, 1'b1);
        chk("stall_C_const", 32'(out_C), 32'h5);
        chk("stall_valid_const", 32'(out_valid), 32'd1);
        drive("stall_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_single_valid", 32'(out_valid), 32'd0);

        // Early marker after slot 1, then three slots complete the new frame.
        drive("early_s0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive("early_s1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("early_mk", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("early_err_const", 32'(out_err), 32'd1);
        chk("early_C_hold", 32'(out_C), 32'h5);
        drive("early_s1b", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive("early_s2b", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive("early_s3b", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("early_C_const", 32'(out_C), 32'hb);
        chk("early_D_const", 32'(out_D), 32'h6);

        // Missing marker at slot 0.
        drive("miss", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("miss_err_const", 32'(out_err), 32'd1);
        chk("miss_locked_const", 32'(out_locked), 32'd0);
        for (int i = 0; i < 5; i++)
            drive("miss_hunt", 1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        send_frame("relock", 4'b0011, 4'b1100, 4'b0000, 4'b0000, 1'b0);

        for (int i = 0; i < 400; i++)
            drive("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

        do_reset();
        for (int i = 0; i < 256; i++)
            send_frame("wrap", 4'($urandom), 4'($urandom), 4'b0000, 4'b0000, 1'b0);
        chk("wrap_cnt_zero", 32'(out_frame_cnt), 32'd0);

        // Reset asserted between edges in the middle of a frame.
        drive("mid_s0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive("mid_s1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        in_rst_n = 1'b0;
        #1;
        chk("mid_rst_C", 32'(out_C), 32'd0);
        chk("mid_rst_locked", 32'(out_locked), 32'd0);
        model_reset();
        check_all("mid_rst");
        @(negedge in_clk);
        in_rst_n = 1'b1;
        drive("post_rst", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame("post_rst_frame", 4'b1001, 4'b0101, 4'b0000, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
